// File: rtl/eq_pkg.sv
// eq_pkg: shared constants, types and band indices for the equaliser band mixer
package eq_pkg;
    localparam int NUM_BANDS = 10;
    localparam int DATA_W    = 24;
    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 12;
    localparam int ACC_W     = DATA_W + GAIN_W + 4;
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [GAIN_W-1:0] gain_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    localparam gain_t GAIN_UNITY = 16'sh1000;
    localparam gain_t GAIN_RESET = GAIN_UNITY;
    localparam int BAND_LP   = 0;
    localparam int BAND_64   = 1;
    localparam int BAND_125  = 2;
    localparam int BAND_250  = 3;
    localparam int BAND_500  = 4;
    localparam int BAND_1K   = 5;
    localparam int BAND_2K   = 6;
    localparam int BAND_4K   = 7;
    localparam int BAND_8K   = 8;
    localparam int BAND_HP   = 9;
endpackage

// File: rtl/eq_band_mixer_if.sv
// eq_band_mixer_if: sample/gain-write inputs and equalised-sample outputs of the band mixer
// master drives sample_valid, band_samples, gain_wr_*; slave drives out_*, busy, overrun
interface eq_band_mixer_if import eq_pkg::*; ();
    logic                        sample_valid;
    logic [NUM_BANDS*DATA_W-1:0] band_samples;
    logic                        gain_wr_en;
    logic [3:0]                  gain_wr_addr;
    gain_t                       gain_wr_data;
    sample_t                     out_sample;
    logic                        out_valid;
    logic                        out_sat;
    logic                        busy;
    logic                        overrun;
    modport master (
        output sample_valid, band_samples, gain_wr_en, gain_wr_addr, gain_wr_data,
        input  out_sample, out_valid, out_sat, busy, overrun
    );
    modport slave (
        input  sample_valid, band_samples, gain_wr_en, gain_wr_addr, gain_wr_data,
        output out_sample, out_valid, out_sat, busy, overrun
    );
endinterface

// File: rtl/eq_round_sat.sv
// eq_round_sat: round-half-up shift of a Q.12 accumulator down to a saturated sample
// acc in, y = saturated rounded sample, clip = saturation occurred
module eq_round_sat import eq_pkg::*; (
    input  acc_t    acc,
    output sample_t y,
    output logic    clip
);
    localparam acc_t SAT_MAX = acc_t'((1 <<< (DATA_W-1)) - 1);
    localparam acc_t SAT_MIN = -SAT_MAX - 1;
    localparam acc_t HALF    = acc_t'(1) <<< (GAIN_FRAC-1);
    acc_t rnd;
    logic hi, lo;
    always_comb begin
        rnd  = (acc + HALF) >>> GAIN_FRAC;
        hi   = rnd > SAT_MAX;
        lo   = rnd < SAT_MIN;
        clip = hi | lo;
        y    = hi ? sample_t'(SAT_MAX) : lo ? sample_t'(SAT_MIN) : sample_t'(rnd);
    end
endmodule

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: weights ten band samples by programmable gains and sums them on one MAC
// clk, reset (sync, active-high); bus = eq_band_mixer_if slave port
module eq_band_mixer import eq_pkg::*; (
    input logic            clk,
    input logic            reset,
    eq_band_mixer_if.slave bus
);
    state_t     state;
    gain_t      gains  [NUM_BANDS];
    gain_t      gain_w [NUM_BANDS];
    sample_t    band_w [NUM_BANDS];
    acc_t       acc, acc_next;
    logic [3:0] cnt;
    sample_t    rs_y;
    logic       rs_clip;
    assign acc_next = acc + acc_t'(band_w[cnt]) * acc_t'(gain_w[cnt]);
    // Rounding looks at acc_next so the result can be registered on the last MAC edge,
    // making out_valid coincide with the OUT cycle.
    eq_round_sat u_round_sat (.acc(acc_next), .y(rs_y), .clip(rs_clip));
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            bus.out_sample <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_sat    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.overrun    <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                gains[k]  <= GAIN_RESET;
                gain_w[k] <= GAIN_RESET;
                band_w[k] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_sat   <= 1'b0;
            if (bus.gain_wr_en && bus.gain_wr_addr < 4'(NUM_BANDS))
                gains[bus.gain_wr_addr] <= bus.gain_wr_data;
            if (bus.sample_valid && state != IDLE)
                bus.overrun <= 1'b1;
            case (state)
                IDLE: if (bus.sample_valid) begin
                    for (int k = 0; k < NUM_BANDS; k++)
                        band_w[k] <= bus.band_samples[k*DATA_W +: DATA_W];
                    gain_w   <= gains;
                    acc      <= '0;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= MAC;
                end
                MAC: begin
                    acc <= acc_next;
                    if (cnt == 4'(NUM_BANDS-1)) begin
                        cnt            <= '0;
                        bus.out_sample <= rs_y;
                        bus.out_valid  <= 1'b1;
                        bus.out_sat    <= rs_clip;
                        state          <= OUT;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                OUT: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer: directed self-checking bench for eq_band_mixer
module tb_eq_band_mixer;
    import eq_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    eq_band_mixer_if bus ();
    eq_band_mixer dut (.clk(clk), .reset(reset), .bus(bus));
    int n_tests = 0;
    int n_fail = 0;
    int lat;
    int busy_cycles;
    sample_t bands [NUM_BANDS];
    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic logic [NUM_BANDS*DATA_W-1:0] pack_bands();
        logic [NUM_BANDS*DATA_W-1:0] p;
        for (int k = 0; k < NUM_BANDS; k++) p[k*DATA_W +: DATA_W] = bands[k];
        return p;
    endfunction
    task automatic set_all(input sample_t v);
        for (int k = 0; k < NUM_BANDS; k++) bands[k] = v;
    endtask
    task automatic wr_gain(input int a, input gain_t d);
        @(negedge clk);
        bus.gain_wr_en   = 1'b1;
        bus.gain_wr_addr = 4'(a);
        bus.gain_wr_data = d;
        @(negedge clk);
        bus.gain_wr_en = 1'b0;
    endtask
    task automatic set_gains(input gain_t d);
        for (int k = 0; k < NUM_BANDS; k++) wr_gain(k, d);
    endtask
    task automatic pulse();
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.band_samples = pack_bands();
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask
    task automatic wait_out(input string tag);
        lat = 1;
        busy_cycles = 0;
        while (!bus.out_valid && lat < 40) begin
            busy_cycles += int'(bus.busy);
            @(negedge clk);
            lat++;
        end
        busy_cycles += int'(bus.busy);
        if (!bus.out_valid) check({tag, " timeout"}, 0, 1);
    endtask
    task automatic run(input string tag, input longint exp_y, input logic exp_sat);
        pulse();
        wait_out(tag);
        check({tag, " y"}, bus.out_sample, exp_y);
        check({tag, " sat"}, bus.out_sat, exp_sat);
    endtask
    initial begin
        int seen;
        bus.sample_valid = 1'b0;
        bus.band_samples = '0;
        bus.gain_wr_en   = 1'b0;
        bus.gain_wr_addr = '0;
        bus.gain_wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst out_sample", bus.out_sample, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_sat", bus.out_sat, 0);
        check("rst busy", bus.busy, 0);
        check("rst overrun", bus.overrun, 0);
        reset = 1'b0;
        set_all(1000);
        run("unity", 10000, 1'b0);
        check("latency", lat, 11);
        check("busy cycles", busy_cycles, 11);
        @(negedge clk);
        check("busy after", bus.busy, 0);
        check("valid pulse", bus.out_valid, 0);
        repeat (3) @(negedge clk);
        check("hold", bus.out_sample, 10000);
        set_gains(16'sh0000);
        wr_gain(3, 16'sh2000);
        set_all(7777);
        bands[3] = -5000;
        run("band3", -10000, 1'b0);
        wr_gain(12, 16'sh7fff);
        run("addr12", -10000, 1'b0);
        set_gains(16'sh7fff);
        set_all(8388607);
        run("sat pos", 8388607, 1'b1);
        set_all(-8388608);
        run("sat neg", -8388608, 1'b1);
        set_gains(16'sh0000);
        wr_gain(0, 16'sh0001);
        set_all(0);
        bands[0] = 2048;
        run("rnd 2048", 1, 1'b0);
        bands[0] = 2047;
        run("rnd 2047", 0, 1'b0);
        bands[0] = -2048;
        run("rnd -2048", 0, 1'b0);
        check("no overrun yet", bus.overrun, 0);
        set_gains(16'sh1000);
        set_all(1000);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.band_samples = pack_bands();
        bus.gain_wr_en   = 1'b1;
        bus.gain_wr_addr = 4'd0;
        bus.gain_wr_data = 16'sh2000;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.gain_wr_en   = 1'b0;
        repeat (4) @(negedge clk);
        set_all(2000);
        bus.sample_valid = 1'b1;
        bus.band_samples = pack_bands();
        @(negedge clk);
        bus.sample_valid = 1'b0;
        wait_out("overrun");
        check("overrun first y", bus.out_sample, 10000);
        check("overrun set", bus.overrun, 1);
        set_all(1000);
        run("gain next", 11000, 1'b0);
        check("overrun sticky", bus.overrun, 1);
        set_gains(16'sh2000);
        pulse();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            seen += int'(bus.out_valid);
        end
        check("abort no valid", seen, 0);
        check("abort busy", bus.busy, 0);
        check("abort overrun", bus.overrun, 0);
        check("abort out_sample", bus.out_sample, 0);
        run("post reset", 10000, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
